// File: rtl/weight_loader.sv
// Weight loader: streams valid/ready weight words into the per-core weight SRAMs, core-major.
// Optional running XOR checksum of the load is enabled with WEIGHT_LOADER_CHECKSUM_EN.
module weight_loader #(
  parameter int P_GROUP        = 64,
  parameter int P_GROUP_LOG2   = 6,
  parameter int P_WORDS_WE     = 256,
  parameter int P_BITWIDTH_WE  = 64,
  parameter int P_ADDRWIDTH_WE = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      abort,
  input  logic [P_ADDRWIDTH_WE-1:0] baseAddr,
  input  logic [P_ADDRWIDTH_WE:0]   numWords,
  input  logic [P_GROUP_LOG2:0]     numCores,
  input  logic                      inValid,
  input  logic [P_BITWIDTH_WE-1:0]  inData,
  output logic                      inReady,
  output logic [P_BITWIDTH_WE-1:0]  weightData,
  output logic [P_ADDRWIDTH_WE-1:0] weightWriteAddr,
  output logic [P_GROUP_LOG2-1:0]   weightWriteSelect,
  output logic                      nWeightWe,
  output logic                      busy,
  output logic                      done,
  output logic                      cfgErr
`ifdef WEIGHT_LOADER_CHECKSUM_EN
  ,
  output logic [P_BITWIDTH_WE-1:0]  loadChecksum
`endif
);

  localparam int AW = P_ADDRWIDTH_WE;
  localparam int GW = P_GROUP_LOG2;
  localparam logic [AW:0] WORDS_MAX = (AW+1)'(P_WORDS_WE);
  localparam logic [GW:0] CORES_MAX = (GW+1)'(P_GROUP);
  localparam logic [AW:0] W_ZERO    = {(AW+1){1'b0}};
  localparam logic [AW:0] W_ONE     = {{AW{1'b0}}, 1'b1};
  localparam logic [GW:0] C_ZERO    = {(GW+1){1'b0}};
  localparam logic [GW:0] C_ONE     = {{GW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                   state_q;
  logic [AW-1:0]            base_q;
  logic [AW:0]              words_q;
  logic [GW:0]              cores_q;
  logic [AW:0]              word_cnt_q, word_cnt_d;
  logic [GW:0]              core_cnt_q, core_cnt_d;
  logic                     we_n_q;
  logic [P_BITWIDTH_WE-1:0] data_q;
  logic [AW-1:0]            addr_q;
  logic [GW-1:0]            sel_q;
  logic                     done_q;
  logic                     cfg_err_q;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
  logic [P_BITWIDTH_WE-1:0] chk_q;
`endif

  logic          in_ready_s;
  logic          accept_s;
  logic          last_word_s;
  logic          last_core_s;
  logic          last_beat_s;
  logic          cfg_ok_s;
  logic [AW-1:0] wr_addr_s;

  always_comb begin
    in_ready_s  = (state_q == S_LOAD) && !abort;
    accept_s    = inValid && in_ready_s;
    last_word_s = (word_cnt_q == (words_q - W_ONE));
    last_core_s = (core_cnt_q == (cores_q - C_ONE));
    last_beat_s = accept_s && last_word_s && last_core_s;
    cfg_ok_s    = (numWords != W_ZERO) && (numWords <= WORDS_MAX) &&
                  (numCores != C_ZERO) && (numCores <= CORES_MAX);
    // Address wraps naturally at the SRAM depth.
    wr_addr_s   = base_q + word_cnt_q[AW-1:0];
    word_cnt_d  = word_cnt_q;
    core_cnt_d  = core_cnt_q;
    if (accept_s) begin
      if (last_word_s) begin
        word_cnt_d = W_ZERO;
        core_cnt_d = core_cnt_q + C_ONE;
      end else begin
        word_cnt_d = word_cnt_q + W_ONE;
      end
    end else begin
      word_cnt_d = word_cnt_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      base_q     <= {AW{1'b0}};
      words_q    <= W_ZERO;
      cores_q    <= C_ZERO;
      word_cnt_q <= W_ZERO;
      core_cnt_q <= C_ZERO;
      we_n_q     <= 1'b1;
      data_q     <= {P_BITWIDTH_WE{1'b0}};
      addr_q     <= {AW{1'b0}};
      sel_q      <= {GW{1'b0}};
      done_q     <= 1'b0;
      cfg_err_q  <= 1'b0;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
      chk_q      <= {P_BITWIDTH_WE{1'b0}};
`endif
    end else begin
      we_n_q     <= 1'b1;
      done_q     <= 1'b0;
      cfg_err_q  <= 1'b0;
      word_cnt_q <= word_cnt_d;
      core_cnt_q <= core_cnt_d;
      if (accept_s) begin
        we_n_q <= 1'b0;
        data_q <= inData;
        addr_q <= wr_addr_s;
        sel_q  <= core_cnt_q[GW-1:0];
`ifdef WEIGHT_LOADER_CHECKSUM_EN
        chk_q  <= chk_q ^ inData;
`endif
      end
      case (state_q)
        S_IDLE: begin
          if (start) begin
            if (cfg_ok_s) begin
              base_q     <= baseAddr;
              words_q    <= numWords;
              cores_q    <= numCores;
              word_cnt_q <= W_ZERO;
              core_cnt_q <= C_ZERO;
              state_q    <= S_LOAD;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
              chk_q      <= {P_BITWIDTH_WE{1'b0}};
`endif
            end else begin
              cfg_err_q <= 1'b1;
            end
          end
        end
        // Last beat moves straight to DONE so inReady drops on the same edge.
        S_LOAD: begin
          if (abort) begin
            state_q <= S_IDLE;
          end else if (last_beat_s) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign inReady           = in_ready_s;
  assign busy              = (state_q != S_IDLE);
  assign nWeightWe         = we_n_q;
  assign weightData        = data_q;
  assign weightWriteAddr   = addr_q;
  assign weightWriteSelect = sel_q;
  assign done              = done_q;
  assign cfgErr            = cfg_err_q;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
  assign loadChecksum      = chk_q;
`endif

endmodule

// File: tb/tb_weight_loader.sv
// Scoreboard bench for weight_loader: a driver pushes the expected write for every accepted beat,
// a negedge monitor pops and compares against each strobe.
module tb_weight_loader;

  logic        clk;
  logic        rst;
  logic        start;
  logic        abort;
  logic [7:0]  baseAddr;
  logic [8:0]  numWords;
  logic [6:0]  numCores;
  logic        inValid;
  logic [63:0] inData;
  logic        inReady;
  logic [63:0] weightData;
  logic [7:0]  weightWriteAddr;
  logic [5:0]  weightWriteSelect;
  logic        nWeightWe;
  logic        busy;
  logic        done;
  logic        cfgErr;
`ifdef WEIGHT_LOADER_CHECKSUM_EN
  logic [63:0] loadChecksum;
`endif

  weight_loader dut (
    .clk               (clk),
    .rst               (rst),
    .start             (start),
    .abort             (abort),
    .baseAddr          (baseAddr),
    .numWords          (numWords),
    .numCores          (numCores),
    .inValid           (inValid),
    .inData            (inData),
    .inReady           (inReady),
    .weightData        (weightData),
    .weightWriteAddr   (weightWriteAddr),
    .weightWriteSelect (weightWriteSelect),
    .nWeightWe         (nWeightWe),
    .busy              (busy),
    .done              (done),
    .cfgErr            (cfgErr)
`ifdef WEIGHT_LOADER_CHECKSUM_EN
    ,
    .loadChecksum      (loadChecksum)
`endif
  );

  typedef struct {
    logic [5:0]  sel;
    logic [7:0]  addr;
    logic [63:0] data;
    logic        dn;
    logic [63:0] cs;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every strobe must match the oldest expected write; bubbles must hold outputs.
  initial begin : monitor
    exp_t        e;
    logic [5:0]  last_sel;
    logic [7:0]  last_addr;
    logic [63:0] last_data;
    last_sel  = 6'd0;
    last_addr = 8'd0;
    last_data = 64'd0;
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        last_sel  = 6'd0;
        last_addr = 8'd0;
        last_data = 64'd0;
      end else if (nWeightWe == 1'b0) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_strobe", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("strobe_sel", 64'(weightWriteSelect), 64'(e.sel));
          chk("strobe_addr", 64'(weightWriteAddr), 64'(e.addr));
          chk("strobe_data", weightData, e.data);
          chk("strobe_done", 64'(done), 64'(e.dn));
`ifdef WEIGHT_LOADER_CHECKSUM_EN
          chk("checksum", loadChecksum, e.cs);
`endif
          last_sel  = e.sel;
          last_addr = e.addr;
          last_data = e.data;
        end
      end else begin
        chk("done_no_strobe", 64'(done), 64'd0);
        chk("hold_sel", 64'(weightWriteSelect), 64'(last_sel));
        chk("hold_addr", 64'(weightWriteAddr), 64'(last_addr));
        chk("hold_data", weightData, last_data);
      end
    end
  end

  // Reference: beat k of a load goes to core k/nw at address (base + k%nw) mod 256.
  task automatic push_exp(input logic [7:0] base, input int nw, input int total, input int k,
                          input logic [63:0] d, inout logic [63:0] cs);
    exp_t e;
    cs     = cs ^ d;
    e.sel  = 6'(k / nw);
    e.addr = base + 8'(k % nw);
    e.data = d;
    e.dn   = (k == total - 1);
    e.cs   = cs;
    exp_q.push_back(e);
  endtask

  // vmode: 0 = valid held high, 1 = pattern 1,0,0,..., 2 = random
  task automatic do_load(input logic [7:0] base, input int nw, input int nc, input int vmode,
                         input int abort_after, input bit seq);
    int          total;
    int          k;
    int          cyc;
    bit          aborted;
    bit          glitched;
    logic [63:0] cs;
    total    = nw * nc;
    k        = 0;
    cyc      = 0;
    aborted  = 1'b0;
    glitched = 1'b0;
    cs       = 64'd0;
    @(posedge clk); #1;
    start    = 1'b1;
    baseAddr = base;
    numWords = 9'(nw);
    numCores = 7'(nc);
    @(posedge clk); #1;
    start = 1'b0;
    while (k < total) begin
      if (cyc > 4 * total + 20) begin
        chk("load_timeout", 64'(k), 64'(total));
        break;
      end
      if (k == abort_after) begin
        abort   = 1'b1;
        inValid = 1'b1;
        @(negedge clk);
        chk("abort_in_ready", 64'(inReady), 64'd0);
        @(posedge clk); #1;
        abort   = 1'b0;
        inValid = 1'b0;
        @(negedge clk);
        chk("abort_busy", 64'(busy), 64'd0);
        aborted = 1'b1;
        break;
      end
      case (vmode)
        0:       inValid = 1'b1;
        1:       inValid = (cyc % 3 == 0);
        default: inValid = 1'($urandom_range(0, 1));
      endcase
      inData = seq ? 64'(k + 1) : {$urandom, $urandom};
      if (!seq && k == 1 && !glitched) begin
        glitched = 1'b1;
        start    = 1'b1;
        baseAddr = ~base;
        numWords = 9'd0;
        numCores = 7'd0;
      end
      @(negedge clk);
      chk("in_ready_load", 64'(inReady), 64'd1);
      chk("busy_load", 64'(busy), 64'd1);
      chk("cfg_err_load", 64'(cfgErr), 64'd0);
      if (inValid && inReady) begin
        push_exp(base, nw, total, k, inData, cs);
        k++;
      end
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
    end
    inValid = 1'b0;
    if (!aborted && k == total) begin
      @(negedge clk);
      chk("in_ready_done", 64'(inReady), 64'd0);
      chk("busy_done", 64'(busy), 64'd1);
      @(posedge clk); #1;
      @(negedge clk);
      chk("busy_after", 64'(busy), 64'd0);
    end
  endtask

  task automatic cfg_err(input int nw, input int nc);
    @(posedge clk); #1;
    start    = 1'b1;
    baseAddr = 8'd5;
    numWords = 9'(nw);
    numCores = 7'(nc);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("cfg_err_pulse", 64'(cfgErr), 64'd1);
    chk("cfg_err_busy", 64'(busy), 64'd0);
    chk("cfg_err_ready", 64'(inReady), 64'd0);
    @(negedge clk);
    chk("cfg_err_clear", 64'(cfgErr), 64'd0);
    chk("cfg_err_busy2", 64'(busy), 64'd0);
  endtask

  task automatic reset_mid_load();
    logic [63:0] cs;
    cs = 64'd0;
    @(posedge clk); #1;
    start    = 1'b1;
    baseAddr = 8'd10;
    numWords = 9'd8;
    numCores = 7'd2;
    @(posedge clk); #1;
    start   = 1'b0;
    inValid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      inData = {$urandom, $urandom};
      @(negedge clk);
      push_exp(8'd10, 8, 16, k, inData, cs);
      @(posedge clk); #1;
    end
    chk("rst_pending_strobe", 64'(nWeightWe), 64'd0);
    rst     = 1'b1;
    inValid = 1'b0;
    #1;
    chk("rst_we_n", 64'(nWeightWe), 64'd1);
    chk("rst_in_ready", 64'(inReady), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_data", weightData, 64'd0);
    chk("rst_addr", 64'(weightWriteAddr), 64'd0);
    chk("rst_sel", 64'(weightWriteSelect), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    @(negedge clk); #2;
    rst = 1'b0;
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b0;
    abort    = 1'b0;
    baseAddr = 8'd0;
    numWords = 9'd0;
    numCores = 7'd0;
    inValid  = 1'b0;
    inData   = 64'd0;
    #3;
    chk("reset_we_n", 64'(nWeightWe), 64'd1);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_ready", 64'(inReady), 64'd0);
    chk("reset_cfg_err", 64'(cfgErr), 64'd0);
    chk("reset_data", weightData, 64'd0);
    @(negedge clk); #2;
    rst = 1'b0;

    do_load(8'd0, 3, 2, 0, -1, 1'b1);
    do_load(8'd0, 3, 2, 1, -1, 1'b1);
    do_load(8'd254, 4, 1, 0, -1, 1'b0);
    cfg_err(0, 1);
    cfg_err(1, 65);
    cfg_err(257, 1);
    cfg_err(3, 0);
    do_load(8'd40, 5, 2, 0, 2, 1'b0);
    do_load(8'd40, 5, 2, 2, -1, 1'b0);
    reset_mid_load();
    repeat (6) begin
      do_load(8'($urandom), int'($urandom_range(1, 8)), int'($urandom_range(1, 4)), 2, -1, 1'b0);
    end
    do_load(8'($urandom), 256, 1, 0, -1, 1'b0);
    do_load(8'($urandom), 1, 64, 2, -1, 1'b0);

    repeat (3) @(negedge clk);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
